mipi_rx_sequencer: RTL and testbench
====================================

MIPI_RX_SEQUENCER -- requirements
Module: mipi_rx_sequencer

Interface
REQ-001 Parameter PWRUP_CYC, default 16: cycles pd_dphy_o held low before lock is checked.
REQ-002 Parameter LOCK_TO, default 4096: cycles allowed for pll_lock_i after PWRUP.
REQ-003 Parameter SYNC_TO, default 1000000: cycles allowed for the first fv_i rise after reset release.
REQ-004 Parameter FRAME_TO, default 2000000: maximum cycles from fv_i fall to the next fv_i rise in RUN.
REQ-005 Parameter MAX_RETRY, default 3: retries before FAULT; EXP_LINES, default 0 (0 = line check off).
REQ-006 clk_i  in  1  sole clock; pixel clock domain.
REQ-007 rst_i  in  1  reset, synchronous to clk_i, active-high.
REQ-008 enable_i  in  1  link enable from host; level.
REQ-009 pll_lock_i  in  1  pixel PLL lock, synchronous to clk_i.
REQ-010 fv_i, lv_i  in  1 each  frame/line valid from byte-to-pixel output, synchronous to clk_i.
REQ-011 pd_dphy_o  out  1  D-PHY power-down, 1 = powered down.
REQ-012 rx_rst_n_o  out  1  D-PHY/byte2pixel reset, 0 = held in reset.
REQ-013 link_up_o  out  1  high only in RUN.
REQ-014 fault_o  out  1  high only in FAULT.
REQ-015 state_o  out  3  OFF=0, PWRUP=1, WAIT_LOCK=2, WAIT_SYNC=3, RUN=4, RETRY=5, FAULT=6.
REQ-016 err_code_o  out  2  last failure: 0 none, 1 lock timeout, 2 sync/frame timeout, 3 lock lost.
REQ-017 retry_cnt_o  out  3  retries since OFF; frame_cnt_o  out  16  completed frames.
REQ-018 lines_o  out  12  line count of the last completed frame; line_err_o  out  1  sticky mismatch flag.

Function
REQ-019 The block SHALL register fv_i and lv_i once (fv_q, lv_q) and detect edges from the current input versus the registered copy.
REQ-020 A single 24-bit timer SHALL clear on every state change and otherwise increment, saturating at all-ones.
REQ-021 enable_i=0 SHALL force OFF on the next edge from any state, with priority over all other transitions.
REQ-022 OFF: pd=1, rst_n=0; retry_cnt_o, err_code_o and line_err_o cleared; enable_i=1 -> PWRUP.
REQ-023 PWRUP: pd=0, rst_n=0; timer==PWRUP_CYC-1 -> WAIT_LOCK.
REQ-024 WAIT_LOCK: pd=0, rst_n=0; pll_lock_i=1 -> WAIT_SYNC; otherwise timer==LOCK_TO-1 -> FAULT, err_code=1 (no retry).
REQ-025 WAIT_SYNC: pd=0, rst_n=1; fv_i rising edge -> RUN; timer==SYNC_TO-1 -> RETRY, err_code=2; pll_lock_i=0 -> RETRY, err_code=3.
REQ-026 RUN: pd=0, rst_n=1, link_up=1; pll_lock_i=0 -> RETRY, err_code=3; timer (cleared at every fv_i fall) reaching FRAME_TO-1 while fv_i=0 -> RETRY, err_code=2.
REQ-027 When lock loss and timeout coincide in the same cycle, err_code SHALL be 3.
REQ-028 RUN line counting: an lv_i rising edge while fv_i=1 SHALL increment a 12-bit counter, saturating at 4095; the counter SHALL clear on each fv_i rising edge.
REQ-029 On an fv_i falling edge in RUN, the block SHALL, on the next edge:
- load lines_o with the count, including an lv_i rise in the same cycle;
- increment frame_cnt_o, wrapping 0xFFFF->0;
- set line_err_o if EXP_LINES!=0 and the count differs from EXP_LINES.
REQ-030 A frame in progress when RUN is left SHALL NOT update frame_cnt_o or lines_o.
REQ-031 RETRY: pd=1, rst_n=0 for exactly one cycle; then retry_cnt_o+1, saturating at 7. If the incremented value > MAX_RETRY -> FAULT, else -> PWRUP.
REQ-032 FAULT: pd=1, rst_n=0, fault_o=1; exits only via enable_i=0 (REQ-021).
REQ-033 All outputs SHALL be registered; pd/rst_n/link_up/fault_o SHALL change in the same cycle state_o changes.

Reset
REQ-034 While rst_i=1, the block SHALL hold state OFF with:
- pd_dphy_o=1 and rx_rst_n_o=0;
- link_up_o=0 and fault_o=0;
- err_code_o=0, retry_cnt_o=0, frame_cnt_o=0, lines_o=0, line_err_o=0;
- fv_q=0, lv_q=0, timer 0.
REQ-035 Reset asserted mid-operation (any state) SHALL take effect at the next clk_i edge, with no partial frame update.

Verification
REQ-036 Sequence:
- stimulus: enable_i=1, pll_lock_i=1 at cycle 0, fv_i rise later;
- response: state PWRUP then WAIT_LOCK after 16 cycles, WAIT_SYNC one cycle later, RUN one cycle after the fv_i rise, link_up_o=1.
REQ-037 Line counting:
- stimulus: EXP_LINES=4; a frame with 4 lv_i pulses, then a frame with 3;
- response: after the first frame, lines_o=4, frame_cnt_o=1, line_err_o=0; after the second, lines_o=3, frame_cnt_o=2, line_err_o=1 (sticky).
REQ-038 Lock timeout:
- stimulus: pll_lock_i held 0;
- response: FAULT exactly LOCK_TO cycles after WAIT_LOCK entry, err_code_o=1, pd_dphy_o=1; enable_i low then high restarts from PWRUP with retry_cnt_o=0.
REQ-039 Sync timeout:
- stimulus: lock present, fv_i never rises, MAX_RETRY=3;
- response: three RETRY passes (retry_cnt_o 1,2,3), fourth timeout -> FAULT, err_code_o=2.
REQ-040 Lock loss with coincident timeout:
- stimulus: in RUN, pll_lock_i drops in the same cycle as frame timeout expiry;
- response: RETRY, err_code_o=3, link_up_o=0 the next cycle, frame_cnt_o unchanged.
REQ-041 Forced OFF:
- stimulus: enable_i=0 during RUN mid-frame;
- response: OFF next cycle, pd_dphy_o=1, rx_rst_n_o=0, lines_o and frame_cnt_o unchanged.

Source files
------------

// File: rtl/mipi_rx_sequencer_if.sv
// PHY-side bundle of the MIPI receive sequencer: PLL lock and pixel framing in,
// D-PHY power/reset control out.
interface mipi_rx_sequencer_if;
  // No valid/ready handshake: fv_i/lv_i are level qualifiers sampled every clk_i
  // cycle with no backpressure. pd_dphy_o and rx_rst_n_o are registered levels.
  logic pll_lock_i;
  logic fv_i;
  logic lv_i;
  logic pd_dphy_o;
  logic rx_rst_n_o;

  modport master (
    input  pll_lock_i, fv_i, lv_i,
    output pd_dphy_o, rx_rst_n_o
  );

  modport slave (
    output pll_lock_i, fv_i, lv_i,
    input  pd_dphy_o, rx_rst_n_o
  );
endinterface

// File: rtl/mipi_rx_sequencer.sv
// MIPI CSI-2 receive link sequencer: powers up the D-PHY, waits for PLL lock and
// the first frame, supervises frames and lines, and retries or faults on errors.
module mipi_rx_sequencer #(
  parameter int PWRUP_CYC = 16,
  parameter int LOCK_TO   = 4096,
  parameter int SYNC_TO   = 1000000,
  parameter int FRAME_TO  = 2000000,
  parameter int MAX_RETRY = 3,
  parameter int EXP_LINES = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 enable_i,
  mipi_rx_sequencer_if.master  phy,
  output logic                 link_up_o,
  output logic                 fault_o,
  output logic [2:0]           state_o,
  output logic [1:0]           err_code_o,
  output logic [2:0]           retry_cnt_o,
  output logic [15:0]          frame_cnt_o,
  output logic [11:0]          lines_o,
  output logic                 line_err_o
);

  typedef enum logic [2:0] {
    S_OFF       = 3'd0,
    S_PWRUP     = 3'd1,
    S_WAIT_LOCK = 3'd2,
    S_WAIT_SYNC = 3'd3,
    S_RUN       = 3'd4,
    S_RETRY     = 3'd5,
    S_FAULT     = 3'd6
  } state_t;

  localparam logic [23:0] PWRUP_LAST = 24'(PWRUP_CYC - 1);
  localparam logic [23:0] LOCK_LAST  = 24'(LOCK_TO - 1);
  localparam logic [23:0] SYNC_LAST  = 24'(SYNC_TO - 1);
  localparam logic [23:0] FRAME_LAST = 24'(FRAME_TO - 1);
  localparam logic [2:0]  MAX_R      = 3'(MAX_RETRY);
  localparam logic [11:0] EXP_L      = 12'(EXP_LINES);

  state_t      state_q, state_d;
  logic [23:0] timer_q;
  logic        fv_q, lv_q;
  logic [1:0]  err_q, err_d;
  logic [2:0]  retry_q, retry_inc;
  logic [11:0] line_q, line_d, line_sat;
  logic        pd_q, rst_n_q, link_q, fault_q;
  logic [15:0] frame_q;
  logic [11:0] lines_q;
  logic        line_err_q;
  logic        fv_rise, fv_fall, lv_rise, frame_done;

  assign fv_rise = phy.fv_i & ~fv_q;
  assign fv_fall = ~phy.fv_i & fv_q;
  assign lv_rise = phy.lv_i & ~lv_q;

  assign retry_inc = (retry_q == 3'd7) ? 3'd7 : retry_q + 3'd1;
  assign line_sat  = (line_q == 12'hFFF) ? line_q : line_q + 12'd1;

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    case (state_q)
      S_OFF:       if (enable_i) state_d = S_PWRUP;
      S_PWRUP:     if (timer_q == PWRUP_LAST) state_d = S_WAIT_LOCK;
      S_WAIT_LOCK: begin
        if (phy.pll_lock_i) state_d = S_WAIT_SYNC;
        else if (timer_q == LOCK_LAST) begin
          state_d = S_FAULT;
          err_d   = 2'd1;
        end
      end
      S_WAIT_SYNC: begin
        // Lock loss is checked first so a coincident timeout reports code 3.
        if (!phy.pll_lock_i) begin
          state_d = S_RETRY;
          err_d   = 2'd3;
        end else if (fv_rise) state_d = S_RUN;
        else if (timer_q == SYNC_LAST) begin
          state_d = S_RETRY;
          err_d   = 2'd2;
        end
      end
      S_RUN: begin
        if (!phy.pll_lock_i) begin
          state_d = S_RETRY;
          err_d   = 2'd3;
        end else if (!phy.fv_i && !fv_fall && timer_q == FRAME_LAST) begin
          state_d = S_RETRY;
          err_d   = 2'd2;
        end
      end
      S_RETRY:     state_d = (retry_inc > MAX_R) ? S_FAULT : S_PWRUP;
      S_FAULT:     state_d = S_FAULT;
      default:     state_d = S_OFF;
    endcase
    if (!enable_i) state_d = S_OFF;
    if (state_d == S_OFF) err_d = 2'd0;
  end

  // An lv_i rise coincident with the fv_i fall still belongs to the closing frame.
  always_comb begin
    line_d = line_q;
    if (fv_rise) line_d = lv_rise ? 12'd1 : 12'd0;
    else if (lv_rise && (phy.fv_i || fv_q)) line_d = line_sat;
  end

  assign frame_done = (state_q == S_RUN) && (state_d == S_RUN) && fv_fall;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_OFF;
      timer_q    <= 24'd0;
      fv_q       <= 1'b0;
      lv_q       <= 1'b0;
      err_q      <= 2'd0;
      retry_q    <= 3'd0;
      line_q     <= 12'd0;
      pd_q       <= 1'b1;
      rst_n_q    <= 1'b0;
      link_q     <= 1'b0;
      fault_q    <= 1'b0;
      frame_q    <= 16'd0;
      lines_q    <= 12'd0;
      line_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fv_q    <= phy.fv_i;
      lv_q    <= phy.lv_i;
      err_q   <= err_d;
      line_q  <= line_d;

      if (state_d != state_q) timer_q <= 24'd0;
      else if (state_q == S_RUN && fv_fall) timer_q <= 24'd0;
      else if (timer_q != 24'hFFFFFF) timer_q <= timer_q + 24'd1;

      if (state_d == S_OFF) retry_q <= 3'd0;
      else if (state_q == S_RETRY) retry_q <= retry_inc;

      // Control outputs follow state_d so they move on the same edge as state_o.
      pd_q    <= (state_d == S_OFF) || (state_d == S_RETRY) || (state_d == S_FAULT);
      rst_n_q <= (state_d == S_WAIT_SYNC) || (state_d == S_RUN);
      link_q  <= (state_d == S_RUN);
      fault_q <= (state_d == S_FAULT);

      if (frame_done) begin
        lines_q <= line_d;
        frame_q <= frame_q + 16'd1;
      end

      if (state_d == S_OFF) line_err_q <= 1'b0;
      else if (frame_done && EXP_LINES != 0 && line_d != EXP_L) line_err_q <= 1'b1;
    end
  end

  assign phy.pd_dphy_o  = pd_q;
  assign phy.rx_rst_n_o = rst_n_q;
  assign link_up_o      = link_q;
  assign fault_o        = fault_q;
  assign state_o        = state_q;
  assign err_code_o     = err_q;
  assign retry_cnt_o    = retry_q;
  assign frame_cnt_o    = frame_q;
  assign lines_o        = lines_q;
  assign line_err_o     = line_err_q;

endmodule

// File: tb/tb_mipi_rx_sequencer.sv
// Directed bench for mipi_rx_sequencer: power-up, line counting, lock and sync
// timeouts, lock loss at frame timeout, forced off and mid-run reset.
module tb_mipi_rx_sequencer;

  localparam int PWRUP_CYC = 16;
  localparam int LOCK_TO   = 64;
  localparam int SYNC_TO   = 100;
  localparam int FRAME_TO  = 200;
  localparam int MAX_RETRY = 3;
  localparam int EXP_LINES = 4;

  localparam logic [2:0] S_OFF = 3'd0, S_PWRUP = 3'd1, S_WAIT_LOCK = 3'd2,
                         S_WAIT_SYNC = 3'd3, S_RUN = 3'd4, S_RETRY = 3'd5,
                         S_FAULT = 3'd6;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  logic enable;
  always #5 clk = ~clk;

  mipi_rx_sequencer_if phy ();

  logic        link_up, fault;
  logic [2:0]  state;
  logic [1:0]  err_code;
  logic [2:0]  retry_cnt;
  logic [15:0] frame_cnt;
  logic [11:0] lines;
  logic        line_err;

  mipi_rx_sequencer #(
    .PWRUP_CYC (PWRUP_CYC),
    .LOCK_TO   (LOCK_TO),
    .SYNC_TO   (SYNC_TO),
    .FRAME_TO  (FRAME_TO),
    .MAX_RETRY (MAX_RETRY),
    .EXP_LINES (EXP_LINES)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .enable_i    (enable),
    .phy         (phy),
    .link_up_o   (link_up),
    .fault_o     (fault),
    .state_o     (state),
    .err_code_o  (err_code),
    .retry_cnt_o (retry_cnt),
    .frame_cnt_o (frame_cnt),
    .lines_o     (lines),
    .line_err_o  (line_err)
  );

  // scoreboard counters
  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic lv_pulse();
    phy.lv_i = 1'b1;
    tick();
    phy.lv_i = 1'b0;
    tick();
  endtask

  task automatic wait_state(input string tag, input logic [2:0] s, input int limit,
                            output int cyc);
    cyc = 0;
    while (state !== s && cyc < limit) begin
      tick();
      cyc++;
    end
    check(tag, state, s);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    rst = 1'b1;
    enable = 1'b0;
    phy.pll_lock_i = 1'b0;
    phy.fv_i = 1'b0;
    phy.lv_i = 1'b0;
    tick(3);

    // reset state
    check("rst_state", state, S_OFF);
    check("rst_pd", phy.pd_dphy_o, 1'b1);
    check("rst_rstn", phy.rx_rst_n_o, 1'b0);
    check("rst_link", link_up, 1'b0);
    check("rst_fault", fault, 1'b0);
    check("rst_err", err_code, 2'd0);
    check("rst_retry", retry_cnt, 3'd0);
    check("rst_frames", frame_cnt, 16'd0);
    check("rst_lines", lines, 12'd0);
    check("rst_line_err", line_err, 1'b0);

    // power-up sequence with lock present
    rst = 1'b0;
    enable = 1'b1;
    phy.pll_lock_i = 1'b1;
    tick();
    check("pwrup_state", state, S_PWRUP);
    check("pwrup_pd", phy.pd_dphy_o, 1'b0);
    check("pwrup_rstn", phy.rx_rst_n_o, 1'b0);
    tick(PWRUP_CYC - 1);
    check("pwrup_hold", state, S_PWRUP);
    tick();
    check("wait_lock_entry", state, S_WAIT_LOCK);
    tick();
    check("wait_sync_entry", state, S_WAIT_SYNC);
    check("wait_sync_rstn", phy.rx_rst_n_o, 1'b1);
    check("wait_sync_link", link_up, 1'b0);
    tick(3);
    phy.fv_i = 1'b1;
    tick();
    check("run_entry", state, S_RUN);
    check("run_link", link_up, 1'b1);

    // frame 1: four lines, matches EXP_LINES
    repeat (4) lv_pulse();
    phy.fv_i = 1'b0;
    tick();
    check("f1_lines", lines, 12'd4);
    check("f1_frames", frame_cnt, 16'd1);
    check("f1_line_err", line_err, 1'b0);
    tick(3);

    // frame 2: three lines, sets sticky error
    phy.fv_i = 1'b1;
    tick();
    repeat (3) lv_pulse();
    phy.fv_i = 1'b0;
    tick();
    check("f2_lines", lines, 12'd3);
    check("f2_frames", frame_cnt, 16'd2);
    check("f2_line_err", line_err, 1'b1);
    tick(3);

    // frame 3: fourth lv rise lands on the fv fall cycle; error stays sticky
    phy.fv_i = 1'b1;
    tick();
    repeat (3) lv_pulse();
    phy.lv_i = 1'b1;
    phy.fv_i = 1'b0;
    tick();
    phy.lv_i = 1'b0;
    check("f3_lines", lines, 12'd4);
    check("f3_frames", frame_cnt, 16'd3);
    check("f3_line_err_sticky", line_err, 1'b1);
    tick(3);

    // forced OFF mid-frame
    phy.fv_i = 1'b1;
    tick();
    repeat (2) lv_pulse();
    enable = 1'b0;
    tick();
    check("off_state", state, S_OFF);
    check("off_pd", phy.pd_dphy_o, 1'b1);
    check("off_rstn", phy.rx_rst_n_o, 1'b0);
    check("off_link", link_up, 1'b0);
    check("off_lines", lines, 12'd4);
    check("off_frames", frame_cnt, 16'd3);
    check("off_line_err_clr", line_err, 1'b0);
    phy.fv_i = 1'b0;
    tick(2);

    // lock timeout
    phy.pll_lock_i = 1'b0;
    enable = 1'b1;
    tick();
    check("lto_pwrup", state, S_PWRUP);
    tick(PWRUP_CYC);
    check("lto_wait_lock", state, S_WAIT_LOCK);
    tick(LOCK_TO - 1);
    check("lto_hold", state, S_WAIT_LOCK);
    tick();
    check("lto_fault", state, S_FAULT);
    check("lto_err", err_code, 2'd1);
    check("lto_pd", phy.pd_dphy_o, 1'b1);
    check("lto_fault_o", fault, 1'b1);
    tick(5);
    check("lto_fault_stays", state, S_FAULT);
    enable = 1'b0;
    tick();
    check("lto_off", state, S_OFF);
    check("lto_err_clr", err_code, 2'd0);
    phy.pll_lock_i = 1'b1;
    enable = 1'b1;
    tick();
    check("lto_restart", state, S_PWRUP);
    check("lto_retry_zero", retry_cnt, 3'd0);

    // sync timeout: three retries, fourth timeout faults
    for (int i = 1; i <= 4; i++) begin
      wait_state("sto_reach_sync", S_WAIT_SYNC, 40, cyc);
      wait_state("sto_reach_retry", S_RETRY, SYNC_TO + 20, cyc);
      check("sto_sync_cycles", cyc, SYNC_TO);
      check("sto_err", err_code, 2'd2);
      check("sto_retry_pd", phy.pd_dphy_o, 1'b1);
      check("sto_retry_rstn", phy.rx_rst_n_o, 1'b0);
      tick();
      if (i < 4) begin
        check("sto_pwrup", state, S_PWRUP);
        check("sto_retry_cnt", retry_cnt, 3'(i));
      end else begin
        check("sto_fault", state, S_FAULT);
        check("sto_fault_err", err_code, 2'd2);
        check("sto_fault_o", fault, 1'b1);
      end
    end
    enable = 1'b0;
    tick();
    enable = 1'b1;
    tick();

    // lock loss coincident with frame timeout
    wait_state("ll_reach_sync", S_WAIT_SYNC, 40, cyc);
    phy.fv_i = 1'b1;
    tick();
    check("ll_run", state, S_RUN);
    phy.fv_i = 1'b0;
    tick();
    check("ll_frames", frame_cnt, 16'd4);
    check("ll_lines", lines, 12'd0);
    check("ll_line_err", line_err, 1'b1);
    tick(FRAME_TO - 1);
    check("ll_still_run", state, S_RUN);
    phy.pll_lock_i = 1'b0;
    tick();
    check("ll_retry", state, S_RETRY);
    check("ll_err", err_code, 2'd3);
    check("ll_link", link_up, 1'b0);
    check("ll_frames_kept", frame_cnt, 16'd4);

    // reset mid-operation
    rst = 1'b1;
    tick();
    check("mrst_state", state, S_OFF);
    check("mrst_frames", frame_cnt, 16'd0);
    check("mrst_err", err_code, 2'd0);
    check("mrst_pd", phy.pd_dphy_o, 1'b1);
    rst = 1'b0;
    tick();

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
